// File: rtl/tuning_pkg.sv
// Shared types and default constants for the capacitor-board tuning bus driver.
package tuning_pkg;

  localparam int TUNING_CODE_W      = 7;
  localparam int TUNING_MAX_CODE    = 80;
  localparam int TUNING_SETUP_CYC   = 4;
  localparam int TUNING_ENABLE_CYC  = 8;
  localparam int TUNING_HOLD_CYC    = 2;
  localparam int TUNING_REFRESH_CYC = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } tuning_state_e;

endpackage

// File: rtl/tuning_phase_timer.sv
// Loadable 4-bit down-counter; o_done is high while the count sits at zero.
module tuning_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_done
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/tuning_code_broadcaster.sv
// Tuning bus master: clamps a requested code and broadcasts it with a setup/enable/hold strobe.
// Optional periodic rebroadcast of the last code is enabled by defining TUNING_REFRESH_EN.
module tuning_code_broadcaster
  import tuning_pkg::*;
#(
  parameter int CODE_W      = TUNING_CODE_W,
  parameter int MAX_CODE    = TUNING_MAX_CODE,
  parameter int SETUP_CYC   = TUNING_SETUP_CYC,
  parameter int ENABLE_CYC  = TUNING_ENABLE_CYC,
  parameter int HOLD_CYC    = TUNING_HOLD_CYC,
  parameter int REFRESH_CYC = TUNING_REFRESH_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  output logic [CODE_W-1:0] tuningCode,
  output logic              enable,
  output logic              busy,
  output logic [CODE_W-1:0] cur_code,
  output logic              clamp_err
);

  tuning_state_e     r_state;
  logic              r_req_ready;
  logic [CODE_W-1:0] r_tuning_code;
  logic              r_enable;
  logic              r_busy;
  logic [CODE_W-1:0] r_cur_code;
  logic              r_clamp_err;

  logic              w_accept;
  logic              w_over;
  logic              w_refresh_fire;
  logic              w_start;
  logic [CODE_W-1:0] w_clamped;
  logic [CODE_W-1:0] w_start_code;
  logic              w_load;
  logic [3:0]        w_load_val;
  logic              w_done;

  assign w_accept     = req_valid && r_req_ready;
  assign w_over       = (req_code > CODE_W'(MAX_CODE));
  assign w_clamped    = w_over ? CODE_W'(MAX_CODE) : req_code;
  assign w_start      = w_accept || w_refresh_fire;
  assign w_start_code = w_accept ? w_clamped : r_cur_code;

`ifdef TUNING_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_CYC) + 1;

  logic [REF_W-1:0] r_refresh_cnt;

  // A pending request always beats an expiring refresh.
  assign w_refresh_fire = (r_state == ST_IDLE) && !req_valid &&
                          (r_refresh_cnt == REF_W'(REFRESH_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh_cnt <= '0;
    end else if ((r_state != ST_IDLE) || w_start) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + REF_W'(1);
    end
  end
`else
  logic w_unused_refresh;

  assign w_refresh_fire   = 1'b0;
  assign w_unused_refresh = ^REFRESH_CYC;
`endif

  // Each phase reloads the shared timer with (length-1) as it is entered.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = 4'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_load     = 1'b1;
          w_load_val = 4'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (w_done) begin
          w_load     = 1'b1;
          w_load_val = 4'(ENABLE_CYC - 1);
        end
      end
      ST_STROBE: begin
        if (w_done) begin
          w_load     = 1'b1;
          w_load_val = 4'(HOLD_CYC - 1);
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = 4'd0;
      end
    endcase
  end

  tuning_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b1;
      r_tuning_code <= '0;
      r_enable      <= 1'b0;
      r_busy        <= 1'b0;
      r_cur_code    <= '0;
      r_clamp_err   <= 1'b0;
    end else begin
      r_clamp_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state       <= ST_SETUP;
            r_tuning_code <= w_start_code;
            r_cur_code    <= w_start_code;
            r_busy        <= 1'b1;
            r_req_ready   <= 1'b0;
            r_clamp_err   <= w_accept && w_over;
          end
        end
        ST_SETUP: begin
          if (w_done) begin
            r_state  <= ST_STROBE;
            r_enable <= 1'b1;
          end
        end
        ST_STROBE: begin
          if (w_done) begin
            r_state  <= ST_HOLD;
            r_enable <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_done) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign tuningCode = r_tuning_code;
  assign enable     = r_enable;
  assign busy       = r_busy;
  assign cur_code   = r_cur_code;
  assign clamp_err  = r_clamp_err;

endmodule

// File: tb/tb_tuning_code_broadcaster.sv
// Directed bench for tuning_code_broadcaster, including a behavioural board-1 decoder.
module tb_tuning_code_broadcaster;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [6:0] req_code;
  logic       req_ready;
  logic [6:0] tuningCode;
  logic       enable;
  logic       busy;
  logic [6:0] cur_code;
  logic       clamp_err;

  int checks;
  int errors;

  tuning_code_broadcaster #(.REFRESH_CYC(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (req_ready),
    .tuningCode (tuningCode),
    .enable     (enable),
    .busy       (busy),
    .cur_code   (cur_code),
    .clamp_err  (clamp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board at address 1 owns IDs 4..7 and latches after 4 consecutive high enable clocks.
  logic [3:0] board_out;
  int         en_run;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_run    <= 0;
      board_out <= 4'b0000;
    end else if (enable) begin
      en_run <= en_run + 1;
      if (en_run == 3) begin
        for (int i = 0; i < 4; i++) board_out[i] <= (int'(tuningCode) > 4 + i);
      end
    end else begin
      en_run <= 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [6:0] code, output bit ok);
    ok = 1'b0;
    req_code  = code;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_code = 7'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tuningCode, enable, busy, cur_code, clamp_err, req_ready} !== {7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_in tc=%0d en=%b busy=%b cur=%0d clamp=%b rdy=%b want 0 0 0 0 0 1",
               tuningCode, enable, busy, cur_code, clamp_err, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({tuningCode, enable, busy, req_ready} !== {7'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_out tc=%0d en=%b busy=%b rdy=%b want 0 0 0 1", tuningCode, enable, busy, req_ready);
    end
  endtask

  task automatic test_basic;
    bit ok;
    int highs;
    logic exp_en;
    highs = 0;
    send(7'd13, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_accept got timeout want accept"); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      exp_en = (k >= 5 && k <= 12);
      if (enable === 1'b1) highs++;
      checks++;
      if (enable !== exp_en) begin errors++; $display("FAIL basic_enable k=%0d got %b want %b", k, enable, exp_en); end
      checks++;
      if (tuningCode !== 7'd13) begin errors++; $display("FAIL basic_code k=%0d got %0d want 13", k, tuningCode); end
      if (k == 1 || k == 14 || k == 15) begin
        checks++;
        if (busy !== (k != 15) || req_ready !== (k == 15)) begin
          errors++;
          $display("FAIL basic_busy k=%0d busy=%b rdy=%b want %b %b", k, busy, req_ready, (k != 15), (k == 15));
        end
      end
    end
    checks++;
    if (highs != 8) begin errors++; $display("FAIL basic_highs got %0d want 8", highs); end
    checks++;
    if (cur_code !== 7'd13) begin errors++; $display("FAIL basic_cur got %0d want 13", cur_code); end
  endtask

  task automatic test_clamp;
    bit ok;
    send(7'd100, ok);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (ok !== 1'b1 || tuningCode !== 7'd80 || cur_code !== 7'd80 || clamp_err !== 1'b1) begin
      errors++;
      $display("FAIL clamp_hi ok=%b tc=%0d cur=%0d clamp=%b want 1 80 80 1", ok, tuningCode, cur_code, clamp_err);
    end
    @(negedge clk);
    checks++;
    if (clamp_err !== 1'b0) begin errors++; $display("FAIL clamp_pulse got %b want 0", clamp_err); end
    wait_ready(ok);
    send(7'd80, ok);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (ok !== 1'b1 || tuningCode !== 7'd80 || clamp_err !== 1'b0) begin
      errors++;
      $display("FAIL clamp_eq ok=%b tc=%0d clamp=%b want 1 80 0", ok, tuningCode, clamp_err);
    end
    @(negedge clk);
    checks++;
    if (clamp_err !== 1'b0) begin errors++; $display("FAIL clamp_eq2 got %b want 0", clamp_err); end
    wait_ready(ok);
  endtask

  task automatic test_back_to_back;
    bit ok;
    send(7'd13, ok);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) req_code = 7'd40;
      if (k <= 15) begin
        checks++;
        if (tuningCode !== 7'd13) begin errors++; $display("FAIL b2b_hold k=%0d got %0d want 13", k, tuningCode); end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (tuningCode !== 7'd40 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second tc=%0d busy=%b rdy=%b want 40 1 0", tuningCode, busy, req_ready);
    end
    wait_ready(ok);
    checks++;
    if (ok !== 1'b1 || cur_code !== 7'd40) begin errors++; $display("FAIL b2b_done ok=%b cur=%0d want 1 40", ok, cur_code); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    send(7'd13, ok);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    checks++;
    if (enable !== 1'b1) begin errors++; $display("FAIL rmid_pre en=%b want 1", enable); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (enable !== 1'b0 || tuningCode !== 7'd0 || busy !== 1'b0 || cur_code !== 7'd0) begin
      errors++;
      $display("FAIL rmid_async en=%b tc=%0d busy=%b cur=%0d want 0 0 0 0", enable, tuningCode, busy, cur_code);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", req_ready); end
    send(7'd7, ok);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    checks++;
    if (ok !== 1'b1 || tuningCode !== 7'd7 || enable !== 1'b1) begin
      errors++;
      $display("FAIL rmid_after ok=%b tc=%0d en=%b want 1 7 1", ok, tuningCode, enable);
    end
    wait_ready(ok);
  endtask

  task automatic test_board;
    bit ok;
    send(7'd13, ok);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(ok);
    checks++;
    if (ok !== 1'b1 || board_out !== 4'b1111) begin errors++; $display("FAIL board_13 got %b want 1111", board_out); end
    send(7'd0, ok);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(ok);
    checks++;
    if (ok !== 1'b1 || board_out !== 4'b0000) begin errors++; $display("FAIL board_0 got %b want 0000", board_out); end
  endtask

`ifdef TUNING_REFRESH_EN
  task automatic test_refresh;
    bit ok;
    send(7'd25, ok);
    for (int k = 1; k <= 236; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 156) begin req_code = 7'd50; req_valid = 1'b1; end
      if (k == 157) req_valid = 1'b0;
      if (k == 78 || k == 234) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL refresh_early k=%0d busy=%b want 0", k, busy); end
      end
      if (k == 79) begin
        checks++;
        if (busy !== 1'b1 || tuningCode !== 7'd25 || clamp_err !== 1'b0 || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL refresh_fire busy=%b tc=%0d clamp=%b rdy=%b want 1 25 0 0", busy, tuningCode, clamp_err, req_ready);
        end
      end
      if (k == 83) begin
        checks++;
        if (enable !== 1'b1) begin errors++; $display("FAIL refresh_en got %b want 1", enable); end
      end
      if (k == 157) begin
        checks++;
        if (tuningCode !== 7'd50 || busy !== 1'b1) begin
          errors++;
          $display("FAIL refresh_req_wins tc=%0d busy=%b want 50 1", tuningCode, busy);
        end
      end
      if (k == 235) begin
        checks++;
        if (busy !== 1'b1 || tuningCode !== 7'd50) begin
          errors++;
          $display("FAIL refresh_restart busy=%b tc=%0d want 1 50", busy, tuningCode);
        end
      end
    end
    wait_ready(ok);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_clamp;
    test_back_to_back;
    test_reset_mid;
    test_board;
`ifdef TUNING_REFRESH_EN
    test_refresh;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
